gol_gen_scheduler: RTL
======================

// Module: gol_gen_scheduler
// PURPOSE
//  Top-level sequencer for the Game-of-Life core. Starts the field config loader on a load request, then
//  launches generation-step sweeps either periodically (run mode) or one at a time (single step).
//  Owns the double-buffer select and the generation counter. Sits between user controls and the
//  loader/step engines; it is the only block that pulses their go inputs.
// PARAMETERS
//  GEN_PERIOD   25_000_000  cycles from end of one generation to start of next in run mode (>=2)
//  GEN_CNT_W    16          width of generation counter
//  ACK_TIMEOUT  4           cycles allowed between a go pulse and the engine's busy rising (>=2)
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous reset, active-high
//  i_load_req    in   1          1-cycle pulse: (re)load field from config
//  i_run         in   1          level: auto-run generations every GEN_PERIOD
//  i_step        in   1          1-cycle pulse: compute exactly one generation
//  i_load_busy   in   1          loader busy (loader o_is_loading)
//  i_step_busy   in   1          step engine busy
//  o_load_go     out  1          1-cycle go pulse to loader
//  o_step_go     out  1          1-cycle go pulse to step engine
//  o_buf_sel     out  1          buffer being displayed / read; step engine writes !o_buf_sel
//  o_gen_cnt     out  GEN_CNT_W  generations completed since last load
//  o_busy        out  1          high whenever a load or step is in flight
//  o_err         out  1          sticky: an engine failed to acknowledge go within ACK_TIMEOUT
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): state=IDLE, all outputs 0, timer 0, pendings cleared.
//  States: IDLE -> LOAD_GO -> LOAD_ACK -> LOAD_BUSY -> IDLE;
//          IDLE -> STEP_GO -> STEP_ACK -> STEP_BUSY -> SWAP -> IDLE; ERR (terminal until rst).
//  IDLE: timer counts while i_run=1, cleared to 0 while i_run=0. Launch priority per cycle:
//   load pending > step pending > (i_run && timer==GEN_PERIOD-1). Launch clears timer.
//  LOAD_GO/STEP_GO: o_*_go high exactly this one cycle; o_busy high from this state until back in IDLE.
//  *_ACK: wait for matching busy=1; ack counter starts at 0 in GO state; if ACK_TIMEOUT cycles pass
//   without busy -> ERR (o_err=1, o_busy=0, no further go pulses). Busy seen -> *_BUSY.
//  *_BUSY: wait for busy=0 -> LOAD: gen_cnt<=0, buf_sel unchanged, -> IDLE. STEP: -> SWAP.
//  SWAP (1 cycle): buf_sel toggles, gen_cnt+1 (wraps 2^GEN_CNT_W-1 -> 0), -> IDLE.
//  Latency: load_req in IDLE -> o_load_go next cycle. Step in IDLE -> o_step_go next cycle.
//  Run mode: step_go pulses are GEN_PERIOD cycles apart measured IDLE-entry to IDLE-exit,
//   i.e. period = GEN_PERIOD + step duration + 4 control cycles.
//  Pending flags: i_load_req / i_step in any non-ERR state set load_pend / step_pend; cleared on launch.
//   i_load_req and i_step same cycle: both latched, load launched first, step after.
//   A load launch also clears step_pend (stale step against old field dropped).
//   Repeated pulses while pending collapse to one.
//  Busy already high in GO state counts as ack at ACK. Busy dropping in the ACK cycle it rose is legal.
//  i_run toggled mid-step: step completes normally; only timer behaviour changes.
// TESTING (bench: GEN_PERIOD=4, GEN_CNT_W=3, ACK_TIMEOUT=4; engine models raise busy 1 cycle after go)
//  Reset then idle 10 cycles -> o_load_go/o_step_go never pulse; all outputs 0.
//  load_req pulse, loader busy 15 cycles -> one o_load_go, o_busy high throughout, then gen_cnt=0, buf_sel=0.
//  3 i_step pulses spaced after completion, step busy 6 cycles -> 3 o_step_go, buf_sel 0->1->0->1, gen_cnt=3.
//  i_run=1 for 9 steps -> gen_cnt wraps 7->0->1; consecutive step_go spacing = 4+6+4 = 14 cycles.
//  load_req+step same cycle while stepping -> after SWAP: load_go, then step_go; gen_cnt ends 1.
//  Step engine never raises busy -> o_err=1 exactly 4 cycles after step_go; no further go; rst clears.

Source files
------------

// File: rtl/gol_gen_scheduler.sv
// Game-of-Life generation scheduler: launches config loads and generation sweeps (run or single step),
// owns the display buffer select and generation counter; go pulses appear one cycle after launch.
module gol_gen_scheduler #(
    parameter int GEN_PERIOD  = 25_000_000,
    parameter int GEN_CNT_W   = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load_req,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_load_busy,
    input  logic                 i_step_busy,
    output logic                 o_load_go,
    output logic                 o_step_go,
    output logic                 o_buf_sel,
    output logic [GEN_CNT_W-1:0] o_gen_cnt,
    output logic                 o_busy,
    output logic                 o_err
);
    localparam int TMR_W = $clog2(GEN_PERIOD);
    localparam int ACK_W = $clog2(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GEN_PERIOD - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_GO,
        S_LOAD_ACK,
        S_LOAD_BUSY,
        S_STEP_GO,
        S_STEP_ACK,
        S_STEP_BUSY,
        S_SWAP,
        S_ERR
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TMR_W-1:0]       r_timer;
    logic [ACK_W-1:0]       r_ack_cnt;
    logic                   r_ack_early;
    logic                   r_load_pend;
    logic                   r_step_pend;
    logic                   r_step_keep;
    logic                   r_buf_sel;
    logic [GEN_CNT_W-1:0]   r_gen_cnt;

    logic w_load_want;
    logic w_step_want;
    logic w_run_due;
    logic w_launch_load;
    logic w_launch_step;
    logic w_load_done;
    logic w_swap;
    logic w_go_state;
    logic w_ack_state;

    assign w_load_want = r_load_pend | i_load_req;
    assign w_step_want = r_step_pend | i_step;
    assign w_run_due   = i_run && (r_timer == TMR_LAST);
    assign w_go_state  = (r_state == S_LOAD_GO) || (r_state == S_STEP_GO);
    assign w_ack_state = (r_state == S_LOAD_ACK) || (r_state == S_STEP_ACK);

    assign o_buf_sel = r_buf_sel;
    assign o_gen_cnt = r_gen_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_launch_load = 1'b0;
        w_launch_step = 1'b0;
        w_load_done   = 1'b0;
        w_swap        = 1'b0;
        o_load_go     = 1'b0;
        o_step_go     = 1'b0;
        o_busy        = 1'b0;
        o_err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load_want) begin
                    w_launch_load = 1'b1;
                    w_state_nxt   = S_LOAD_GO;
                end else if (w_step_want || w_run_due) begin
                    w_launch_step = 1'b1;
                    w_state_nxt   = S_STEP_GO;
                end
            end
            S_LOAD_GO: begin
                o_load_go   = 1'b1;
                o_busy      = 1'b1;
                w_state_nxt = S_LOAD_ACK;
            end
            S_LOAD_ACK: begin
                o_busy = 1'b1;
                if (i_load_busy || r_ack_early) begin
                    w_state_nxt = S_LOAD_BUSY;
                end else if (r_ack_cnt == ACK_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_LOAD_BUSY: begin
                o_busy = 1'b1;
                if (!i_load_busy) begin
                    w_load_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_STEP_GO: begin
                o_step_go   = 1'b1;
                o_busy      = 1'b1;
                w_state_nxt = S_STEP_ACK;
            end
            S_STEP_ACK: begin
                o_busy = 1'b1;
                if (i_step_busy || r_ack_early) begin
                    w_state_nxt = S_STEP_BUSY;
                end else if (r_ack_cnt == ACK_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_STEP_BUSY: begin
                o_busy = 1'b1;
                if (!i_step_busy) begin
                    w_state_nxt = S_SWAP;
                end
            end
            S_SWAP: begin
                o_busy      = 1'b1;
                w_swap      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                o_err = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run-mode timer only advances while sitting idle; any launch restarts the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_launch_load || w_launch_step || !i_run) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // Ack window counts cycles since the go pulse; a busy already high during go is remembered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_cnt   <= '0;
            r_ack_early <= 1'b0;
        end else begin
            if (w_launch_load || w_launch_step) begin
                r_ack_cnt <= '0;
            end else if (w_go_state || w_ack_state) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end
            if (r_state == S_LOAD_GO) begin
                r_ack_early <= i_load_busy;
            end else if (r_state == S_STEP_GO) begin
                r_ack_early <= i_step_busy;
            end else if (!w_ack_state) begin
                r_ack_early <= 1'b0;
            end
        end
    end

    // A step that arrives with or after a load request survives that load; older steps are stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_pend <= 1'b0;
            r_step_pend <= 1'b0;
            r_step_keep <= 1'b0;
        end else if (r_state != S_ERR) begin
            if (w_launch_load) begin
                r_load_pend <= 1'b0;
                r_step_pend <= r_step_keep | i_step;
                r_step_keep <= 1'b0;
            end else if (w_launch_step) begin
                r_step_pend <= 1'b0;
                r_step_keep <= 1'b0;
            end else begin
                if (i_load_req) begin
                    r_load_pend <= 1'b1;
                end
                if (i_step) begin
                    r_step_pend <= 1'b1;
                end
                if (i_step && (i_load_req || r_load_pend)) begin
                    r_step_keep <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_sel <= 1'b0;
            r_gen_cnt <= '0;
        end else if (w_load_done) begin
            r_gen_cnt <= '0;
        end else if (w_swap) begin
            r_buf_sel <= ~r_buf_sel;
            r_gen_cnt <= r_gen_cnt + 1'b1;
        end
    end

endmodule
